// File: rtl/dcache_ctrl.sv
// MEM-stage data cache controller: direct-mapped, write-back, write-allocate,
// line-wide off-chip memory behind a req/ack handshake, with a pipeline stall.
module dcache_ctrl #(
  parameter int unsigned NUM_SETS   = 32,
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     MemRead_i,
  input  logic                     MemWrite_i,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o,
  output logic                     stall_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [31:0]              mem_addr_o,
  output logic [LINE_WORDS*32-1:0] mem_wdata_o,
  input  logic [LINE_WORDS*32-1:0] mem_rdata_i,
  input  logic                     mem_ack_i
);

  localparam int unsigned LINE_W = LINE_WORDS * 32;
  localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(NUM_SETS);
  localparam int unsigned LSB_W  = OFF_W + 2;
  localparam int unsigned TAG_W  = 32 - LSB_W - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;

  state_t              state;
  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;
  logic [TAG_W-1:0]    tag_arr  [NUM_SETS];
  logic [LINE_W-1:0]   data_arr [NUM_SETS];
  logic [LINE_W-1:0]   fill_buf;

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             req;
  logic             is_store;
  logic             hit;
  logic             unused;

  // Address decode and hit detection
  assign off      = addr_i[LSB_W-1:2];
  assign idx      = addr_i[LSB_W+IDX_W-1:LSB_W];
  assign tag      = addr_i[31:LSB_W+IDX_W];
  assign req      = MemRead_i | MemWrite_i;
  assign is_store = MemWrite_i;
  assign hit      = req & valid[idx] & (tag_arr[idx] == tag) & (state == IDLE);
  assign unused   = ^addr_i[1:0];

  // Stall and load data are combinational so a miss freezes the pipe at once;
  // stall is gated by reset because the request may still be held during it
  assign stall_o = rst_i & req & ~hit;
  assign rdata_o = hit ? data_arr[idx][{off, 5'd0} +: 32] : 32'd0;

  // Control FSM with registered memory-side outputs and line state bits
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      valid       <= '0;
      dirty       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      fill_buf    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit && is_store) begin
            dirty[idx] <= 1'b1;
          end else if (req && !hit) begin
            if (valid[idx] && dirty[idx]) begin
              state       <= WRITEBACK;
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= {tag_arr[idx], idx, LSB_W'(0)};
              mem_wdata_o <= data_arr[idx];
            end else begin
              state      <= ALLOCATE;
              mem_req_o  <= 1'b1;
              mem_we_o   <= 1'b0;
              mem_addr_o <= {tag, idx, LSB_W'(0)};
            end
          end
        end
        WRITEBACK: begin
          // Request drops for a cycle after the ack before the fetch starts
          if (mem_ack_i) begin
            state     <= ALLOCATE;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
          end
        end
        ALLOCATE: begin
          if (!mem_req_o) begin
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= {tag, idx, LSB_W'(0)};
          end else if (mem_ack_i) begin
            state     <= REFILL;
            mem_req_o <= 1'b0;
            fill_buf  <= mem_rdata_i;
          end
        end
        REFILL: begin
          state      <= IDLE;
          valid[idx] <= 1'b1;
          dirty[idx] <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays: line install on refill, word merge on store hit
  always_ff @(posedge clk_i) begin
    if (state == REFILL) begin
      data_arr[idx] <= fill_buf;
      tag_arr[idx]  <= tag;
    end else if (hit && is_store) begin
      data_arr[idx][{off, 5'd0} +: 32] <= wdata_i;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: cold miss, hits, dirty eviction, store miss,
// zero-latency ack and reset in the middle of a line fetch.
module tb_dcache_ctrl;

  logic         clk_i;
  logic         rst_i;
  logic         MemRead_i;
  logic         MemWrite_i;
  logic [31:0]  addr_i;
  logic [31:0]  wdata_i;
  logic [31:0]  rdata_o;
  logic         stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i;
  logic         mem_ack_i;

  int ncmp = 0;
  int nerr = 0;

  dcache_ctrl #(.NUM_SETS(32), .LINE_WORDS(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [255:0] l0;
  logic [255:0] wb_line;

  initial begin
    rst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    addr_i = '0; wdata_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
    l0 = mk_line(32'h1000_0000);
    l0[32 +: 32] = 32'hDEADBEEF;
    #2 rst_i = 1'b0;
    tick(); tick();
    chk("rst_stall", stall_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_rdata", rdata_o, 0);
    MemRead_i = 1'b1; addr_i = 32'h0000_0104;
    #1;
    chk("rst_stall_gated", stall_o, 0);

    // Cold load of 0x104, ack three cycles after req
    rst_i = 1'b1;
    #1;
    chk("cold_stall_same_cycle", stall_o, 1);
    chk("cold_no_req_yet", mem_req_o, 0);
    tick();
    chk("cold_req", mem_req_o, 1);
    chk("cold_we", mem_we_o, 0);
    chk("cold_addr", mem_addr_o, 32'h100);
    chk("cold_stall_alloc", stall_o, 1);
    tick();
    chk("cold_req_hold1", mem_req_o, 1);
    tick();
    chk("cold_addr_hold2", mem_addr_o, 32'h100);
    tick();
    chk("cold_req_ackcyc", mem_req_o, 1);
    mem_ack_i = 1'b1; mem_rdata_i = l0;
    tick();
    mem_ack_i = 1'b0;
    chk("cold_req_drop", mem_req_o, 0);
    chk("cold_stall_refill", stall_o, 1);
    tick();
    chk("cold_stall_done", stall_o, 0);
    chk("cold_rdata", rdata_o, 32'hDEADBEEF);

    // Load hits
    tick();
    chk("hit_stall", stall_o, 0);
    chk("hit_rdata", rdata_o, 32'hDEADBEEF);
    chk("hit_no_req", mem_req_o, 0);
    addr_i = 32'h0000_0100;
    #1;
    chk("hit_word0", rdata_o, 32'h1000_0000);

    // Store hit, then dirty eviction by 0x1108
    MemRead_i = 1'b0; MemWrite_i = 1'b1; addr_i = 32'h0000_0108; wdata_i = 32'h1234_5678;
    #1;
    chk("st_hit_stall", stall_o, 0);
    tick();
    MemWrite_i = 1'b0; MemRead_i = 1'b1;
    #1;
    chk("st_hit_readback", rdata_o, 32'h1234_5678);
    chk("st_hit_no_req", mem_req_o, 0);
    addr_i = 32'h0000_1108;
    #1;
    chk("evict_stall", stall_o, 1);
    tick();
    wb_line = l0;
    wb_line[64 +: 32] = 32'h1234_5678;
    chk("wb_req", mem_req_o, 1);
    chk("wb_we", mem_we_o, 1);
    chk("wb_addr", mem_addr_o, 32'h100);
    chk("wb_wdata", mem_wdata_o, wb_line);
    tick();
    chk("wb_req_hold", mem_req_o, 1);
    chk("wb_addr_hold", mem_addr_o, 32'h100);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    chk("wb_req_drop", mem_req_o, 0);
    chk("wb_stall_gap", stall_o, 1);
    tick();
    chk("alloc_req", mem_req_o, 1);
    chk("alloc_we", mem_we_o, 0);
    chk("alloc_addr", mem_addr_o, 32'h1100);
    mem_ack_i = 1'b1; mem_rdata_i = mk_line(32'hCAFE_0000);
    tick();
    mem_ack_i = 1'b0;
    chk("alloc_req_drop", mem_req_o, 0);
    tick();
    chk("evict_stall_done", stall_o, 0);
    chk("evict_rdata", rdata_o, 32'hCAFE_0002);

    // Store miss to a clean line with zero-latency ack
    MemRead_i = 1'b0; MemWrite_i = 1'b1; addr_i = 32'h0000_2048; wdata_i = 32'hA5A5_A5A5;
    #1;
    chk("stm_stall_c1", stall_o, 1);
    tick();
    chk("stm_stall_c2", stall_o, 1);
    chk("stm_req", mem_req_o, 1);
    chk("stm_no_wb", mem_we_o, 0);
    chk("stm_addr", mem_addr_o, 32'h2040);
    mem_ack_i = 1'b1; mem_rdata_i = mk_line(32'h2000_0000);
    tick();
    mem_ack_i = 1'b0;
    chk("zl_req_drop", mem_req_o, 0);
    chk("stm_stall_c3", stall_o, 1);
    tick();
    chk("stm_stall_done", stall_o, 0);
    tick();
    MemWrite_i = 1'b0; MemRead_i = 1'b1;
    #1;
    chk("stm_merged", rdata_o, 32'hA5A5_A5A5);
    addr_i = 32'h0000_204C;
    #1;
    chk("stm_fill_kept", rdata_o, 32'h2000_0003);

    // Reset while a fetch is outstanding; late ack must be ignored
    addr_i = 32'h0000_3000;
    #1;
    chk("rmid_stall", stall_o, 1);
    tick();
    chk("rmid_req", mem_req_o, 1);
    #3 rst_i = 1'b0;
    #1;
    chk("rmid_req_async", mem_req_o, 0);
    chk("rmid_stall_async", stall_o, 0);
    chk("rmid_rdata", rdata_o, 0);
    chk("rmid_addr", mem_addr_o, 0);
    MemRead_i = 1'b0; mem_ack_i = 1'b1;
    tick();
    rst_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    chk("late_ack_req", mem_req_o, 0);
    chk("late_ack_stall", stall_o, 0);
    MemRead_i = 1'b1; addr_i = 32'h0000_0104;
    #1;
    chk("reread_miss", stall_o, 1);
    tick();
    chk("reread_req", mem_req_o, 1);
    chk("reread_clean_fetch", mem_we_o, 0);
    chk("reread_addr", mem_addr_o, 32'h100);
    mem_ack_i = 1'b1; mem_rdata_i = mk_line(32'h5555_0000);
    tick();
    mem_ack_i = 1'b0;
    tick();
    chk("reread_stall_done", stall_o, 0);
    chk("reread_rdata", rdata_o, 32'h5555_0001);

    MemRead_i = 1'b0;
    #1;
    chk("idle_rdata_zero", rdata_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
